// File: rtl/embaralhador_if.sv
// Deck-shuffler bus: start/ready handshake plus the write/read port
// of the 52 x 4-bit deck memory.
interface embaralhador_if;
  logic       embaralhar_start;
  logic       embaralhar_ok;
  logic       ocupado;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  // Shuffler side: drives the deck memory and the status flags.
  modport master (
    input  embaralhar_start,
    input  mem_rdata,
    output embaralhar_ok,
    output ocupado,
    output mem_addr,
    output mem_we,
    output mem_wdata
  );

  // Environment side: requests shuffles and owns the memory.
  modport slave (
    output embaralhar_start,
    output mem_rdata,
    input  embaralhar_ok,
    input  ocupado,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata
  );
endinterface

// File: rtl/embaralhador.sv
// Deck shuffler: fills the 52-card deck memory with four suits valued
// 1..10,10,10,10 and then performs a Fisher-Yates shuffle using a free-running
// 16-bit LFSR with rejection sampling for the swap index.
module embaralhador #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  embaralhador_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, PICK, RD_I, RD_J, CAP_J, WR_I, WR_J, DONE
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        start_prev;
  logic        accept;
  logic [5:0]  i;
  logic [5:0]  j;
  logic [5:0]  cnt;
  logic [3:0]  rank;
  logic [3:0]  rank_next;
  logic [3:0]  card_next;
  logic [3:0]  tmp_i;
  logic        ok;
  logic        busy;
  logic        we;
  logic [5:0]  addr;
  logic [3:0]  wdata;

  assign bus.embaralhar_ok = ok;
  assign bus.ocupado       = busy;
  assign bus.mem_we        = we;
  assign bus.mem_addr      = addr;
  assign bus.mem_wdata     = wdata;

  assign accept = bus.embaralhar_start && !start_prev &&
                  (state == IDLE || state == DONE);

  // LFSR x^16+x^14+x^13+x^11+1, free-running in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Previous start level for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) start_prev <= 1'b0;
    else       start_prev <= bus.embaralhar_start;
  end

  // Rank within a suit of the next INIT address and its card value.
  always_comb begin
    rank_next = (rank == 4'd12) ? '0 : rank + 4'd1;
    card_next = (rank_next >= 4'd9) ? 4'd10 : rank_next + 4'd1;
  end

  // Main sequencer; outputs are registered for the state being entered.
  // The write data of WR_I is loaded straight from mem_rdata in CAP_J, so
  // mem_wdata itself holds the captured tmp_j.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ok    <= 1'b0;
      busy  <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      i     <= 6'd51;
      j     <= '0;
      cnt   <= '0;
      rank  <= '0;
      tmp_i <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state <= INIT;
            ok    <= 1'b0;
            busy  <= 1'b1;
            i     <= 6'd51;
            cnt   <= '0;
            rank  <= '0;
            we    <= 1'b1;
            addr  <= '0;
            wdata <= 4'd1;
          end
        end
        INIT: begin
          if (cnt == 6'd51) begin
            state <= PICK;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
          end else begin
            cnt   <= cnt + 6'd1;
            rank  <= rank_next;
            addr  <= cnt + 6'd1;
            wdata <= card_next;
          end
        end
        PICK: begin
          if (lfsr[5:0] <= i) begin
            j     <= lfsr[5:0];
            state <= RD_I;
            addr  <= i;
          end
        end
        RD_I: begin
          state <= RD_J;
          addr  <= j;
        end
        RD_J: begin
          tmp_i <= bus.mem_rdata;
          state <= CAP_J;
          addr  <= '0;
        end
        CAP_J: begin
          state <= WR_I;
          we    <= 1'b1;
          addr  <= i;
          wdata <= bus.mem_rdata;
        end
        WR_I: begin
          state <= WR_J;
          addr  <= j;
          wdata <= tmp_i;
        end
        WR_J: begin
          we    <= 1'b0;
          addr  <= '0;
          wdata <= '0;
          i     <= i - 6'd1;
          if (i == 6'd1) begin
            state <= DONE;
            ok    <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= PICK;
          end
        end
        default: begin
          state <= IDLE;
          ok    <= 1'b0;
          busy  <= 1'b0;
          we    <= 1'b0;
          addr  <= '0;
          wdata <= '0;
        end
      endcase
    end
  end

endmodule
